// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter: one-hot + binary grant, held until release, done strobe or hold-limit timeout.
// Latency: request sampled at an edge is granted on that edge; at least one idle cycle separates grants.
module rr_onehot_arbiter #(
    parameter int DEPTH    = 8,
    parameter int IDXW     = $clog2(DEPTH),
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DEPTH-1:0] req,
    input  logic             done,
    output logic [DEPTH-1:0] grant,
    output logic [IDXW-1:0]  grant_idx,
    output logic             grant_valid,
    output logic             timeout
);

    // A zero-width counter is illegal, so a disabled timeout keeps one bit.
    localparam int HCW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t           r_state;
    logic [IDXW-1:0]  r_ptr;
    logic [HCW-1:0]   r_hold_cnt;
    logic [DEPTH-1:0] r_grant;
    logic [IDXW-1:0]  r_grant_idx;
    logic             r_grant_valid;
    logic             r_timeout;

    logic             w_found;
    logic [IDXW-1:0]  w_win;
    logic             w_rel_drop;
    logic             w_rel_done;
    logic             w_rel_limit;
    logic             w_release;
    logic             w_force;

    // Scan starts at r_ptr; index arithmetic wraps because DEPTH is a power of two.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_ptr;
        for (int i = 0; i < DEPTH; i++) begin
            if (!w_found && req[r_ptr + IDXW'(i)]) begin
                w_found = 1'b1;
                w_win   = r_ptr + IDXW'(i);
            end
        end
    end

    always_comb begin
        w_rel_drop  = ~req[r_grant_idx];
        w_rel_done  = done;
        w_rel_limit = (MAX_HOLD != 0) && (r_hold_cnt == HCW'(MAX_HOLD));
        w_release   = w_rel_drop | w_rel_done | w_rel_limit;
        w_force     = w_rel_limit & ~w_rel_drop & ~w_rel_done;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_ptr         <= '0;
            r_hold_cnt    <= '0;
            r_grant       <= '0;
            r_grant_idx   <= '0;
            r_grant_valid <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant       <= DEPTH'(1) << w_win;
                        r_grant_idx   <= w_win;
                        r_grant_valid <= 1'b1;
                        r_hold_cnt    <= HCW'(1);
                        r_state       <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (w_release) begin
                        r_grant       <= '0;
                        r_grant_valid <= 1'b0;
                        r_ptr         <= r_grant_idx + IDXW'(1);
                        r_timeout     <= w_force;
                        r_state       <= S_IDLE;
                    end else if (r_hold_cnt != '1) begin
                        r_hold_cnt <= r_hold_cnt + HCW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign grant       = r_grant;
    assign grant_idx   = r_grant_idx;
    assign grant_valid = r_grant_valid;
    assign timeout     = r_timeout;

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Scoreboard bench for rr_onehot_arbiter (DEPTH=8, MAX_HOLD=4): stimulus queues expected grants,
// the monitor checks index, hold length and timeout of every grant it observes.
module tb_rr_onehot_arbiter;

    localparam int DEPTH    = 8;
    localparam int IDXW     = 3;
    localparam int MAX_HOLD = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [DEPTH-1:0] req;
    logic             done;
    logic [DEPTH-1:0] grant;
    logic [IDXW-1:0]  grant_idx;
    logic             grant_valid;
    logic             timeout;

    rr_onehot_arbiter #(
        .DEPTH   (DEPTH),
        .IDXW    (IDXW),
        .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .done       (done),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_valid(grant_valid),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    // len == 0 marks a grant that reset is expected to cut short.
    typedef struct {
        int idx;
        int len;
        bit to;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_grant(input int idx, input int len, input bit to);
        exp_t e;
        e.idx = idx;
        e.len = len;
        e.to  = to;
        q.push_back(e);
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin
        bit         in_g;
        int         cur_len;
        int         last_idx;
        exp_t       e;
        logic [7:0] one;
        in_g     = 1'b0;
        cur_len  = 0;
        last_idx = 0;
        one      = 8'd1;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (in_g) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL abort_unexpected: got grant cut by reset, expected none");
                    end else begin
                        e = q.pop_front();
                        chk("abort_expected", e.len, 0);
                    end
                end
                in_g     = 1'b0;
                cur_len  = 0;
                last_idx = 0;
            end else if (grant_valid) begin
                if (!in_g) begin
                    in_g    = 1'b1;
                    cur_len = 0;
                end
                cur_len++;
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_grant: got idx %0d, expected no grant", grant_idx);
                end else begin
                    chk("grant_idx", grant_idx, q[0].idx);
                    chk("grant_vec", grant, one << q[0].idx);
                end
            end else if (in_g) begin
                in_g = 1'b0;
                chk("grant_zero_rel", grant, 0);
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL release_unexpected: got release, expected no grant pending");
                end else begin
                    e = q.pop_front();
                    if (e.len == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL abort_missing: got normal release, expected reset abort");
                    end else begin
                        chk("hold_len", cur_len, e.len);
                        chk("timeout_rel", timeout, e.to);
                        chk("idx_kept", grant_idx, e.idx);
                        last_idx = e.idx;
                    end
                end
            end else begin
                chk("grant_zero_idle", grant, 0);
                chk("timeout_idle", timeout, 0);
                chk("idx_idle", grant_idx, last_idx);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected end of stimulus");
        $fatal(1);
    end

    initial begin
        rst  = 1'b1;
        req  = '0;
        done = 1'b0;
        repeat (2) tick();
        rst = 1'b0;

        // Reset mid-grant drops everything without a clock edge.
        req = 8'hFF;
        expect_grant(0, 0, 0);
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_valid", grant_valid, 0);
        chk("rst_idx", grant_idx, 0);
        chk("rst_timeout", timeout, 0);
        req = '0;
        tick();
        rst = 1'b0;
        req = 8'hFF;
        expect_grant(0, 1, 0);
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = '0;
        tick();

        // Single requester, released by dropping its request (ptr=1).
        req = 8'h08;
        expect_grant(3, 2, 0);
        tick();
        tick();
        req = '0;
        tick();
        req = 8'hFF;
        expect_grant(4, 1, 0);
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = '0;
        tick();

        // Full rotation from ptr=0.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            expect_grant(i % 8, 1, 0);
            tick();
            done = 1'b1;
            tick();
            done = 1'b0;
        end

        // Wrap-around: continue to index 6, then ptr=7 with req=0000_0101.
        for (int i = 1; i < 7; i++) begin
            expect_grant(i, 1, 0);
            tick();
            done = 1'b1;
            tick();
            done = 1'b0;
        end
        req = 8'h05;
        expect_grant(0, 1, 0);
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = 8'h85;
        expect_grant(2, 1, 0);
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        expect_grant(7, 1, 0);
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = '0;
        tick();

        // Hold-limit timeout, then done coinciding with the limit.
        req = 8'h03;
        expect_grant(0, 4, 1);
        tick();
        repeat (4) tick();
        expect_grant(1, 4, 0);
        tick();
        repeat (3) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = '0;
        tick();

        // Simultaneous drop and done: ptr must move from 4 to exactly 5.
        req = 8'h30;
        expect_grant(4, 2, 0);
        tick();
        tick();
        req  = 8'h60;
        done = 1'b1;
        tick();
        done = 1'b0;
        expect_grant(5, 1, 0);
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = '0;
        tick();

        // done while idle is ignored and leaves ptr at 6.
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = 8'hFF;
        expect_grant(6, 1, 0);
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = '0;
        repeat (3) tick();

        chk("queue_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
